// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg (package)
// Description : Shared widths and flag bit positions for the register file.
//               XLEN   - data width of every register
//               NREG   - number of architectural registers (x0..x31)
//               REG_AW - register index width
//               FLAG_* - bit positions inside flags_q ({N,Z,C,V})
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int NFLAG  = 4;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/reg_file_flag_reg.sv
`default_nettype none
// ============================================================================
// Module      : flag_reg
// Description : 4-bit enable register holding the captured ALU flags.
//               Synchronous active-high reset clears the register; otherwise
//               it loads i_d when i_en is high and holds otherwise.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               i_en - load enable
//               i_d  - next flag value
//               o_q  - registered flags
// Revision    : 1.0 - initial release
// ============================================================================
module flag_reg
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [NFLAG-1:0] i_d,
    output logic [NFLAG-1:0] o_q
);

    logic [NFLAG-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : flag_reg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32 x 32-bit integer register file with two combinational
//               read ports, one synchronous write port and a 4-bit ALU flag
//               register. x0 is hardwired to zero.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               rs1_addr/rs1_data  - read port 1 (ALU operand A)
//               rs2_addr/rs2_data  - read port 2 (ALU operand B)
//               rd_addr/rd_we/rd_data - write port
//               flag_we, n_f, z_f, c_f, v_f - flag capture
//               flags_q            - registered flags {N,Z,C,V}
// Options     : REGFILE_BYPASS_EN  - when defined, a read of the register
//               being written in the same cycle returns rd_data
//               (write-through). Undefined: the old stored value is returned.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              rd_we,
    input  logic [XLEN-1:0]   rd_data,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              flag_we,
    input  logic              z_f,
    input  logic              n_f,
    input  logic              v_f,
    input  logic              c_f,
    output logic [NFLAG-1:0]  flags_q
);

    localparam logic [REG_AW-1:0] c_zero_addr = '0;

    // Entry 0 is cleared by reset and never written, but the read muxes
    // still force zero so x0 does not depend on that storage element.
    logic [XLEN-1:0] r_regs [NREG];

    logic            w_wr_en;
    logic [XLEN-1:0] w_rs1_stored;
    logic [XLEN-1:0] w_rs2_stored;
    logic [NFLAG-1:0] w_flags_d;

    assign w_wr_en = rd_we && (rd_addr != c_zero_addr);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd_addr] <= rd_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    assign w_rs1_stored = (rs1_addr == c_zero_addr) ? '0 : r_regs[rs1_addr];
    assign w_rs2_stored = (rs2_addr == c_zero_addr) ? '0 : r_regs[rs2_addr];

`ifdef REGFILE_BYPASS_EN
    // Write-through: forward the incoming data unless reset is discarding
    // the write. w_wr_en already excludes x0.
    logic w_byp1;
    logic w_byp2;

    assign w_byp1 = w_wr_en && !rst && (rs1_addr == rd_addr);
    assign w_byp2 = w_wr_en && !rst && (rs2_addr == rd_addr);

    assign rs1_data = w_byp1 ? rd_data : w_rs1_stored;
    assign rs2_data = w_byp2 ? rd_data : w_rs2_stored;
`else
    assign rs1_data = w_rs1_stored;
    assign rs2_data = w_rs2_stored;
`endif

    // ------------------------------------------------------------------------
    // Flags
    // ------------------------------------------------------------------------
    always_comb begin
        w_flags_d         = '0;
        w_flags_d[FLAG_N] = n_f;
        w_flags_d[FLAG_Z] = z_f;
        w_flags_d[FLAG_C] = c_f;
        w_flags_d[FLAG_V] = v_f;
    end

    flag_reg u_flag_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (flag_we),
        .i_d  (w_flags_d),
        .o_q  (flags_q)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file. The stimulus process drives
//               one cycle at a time and queues the expected port values; a
//               monitor pops and compares them on the falling edge.
//               Build with REGFILE_BYPASS_EN to check the write-through build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flag_we;
    logic        z_f;
    logic        n_f;
    logic        v_f;
    logic        c_f;
    logic [3:0]  flags_q;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        int          sel;   // 0: rs1_data, 1: rs2_data, 2: flags_q
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] c_hazard_exp = 32'h2;
`else
    localparam logic [31:0] c_hazard_exp = 32'h1;
`endif

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_addr  (rd_addr),
        .rd_we    (rd_we),
        .rd_data  (rd_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flag_we  (flag_we),
        .z_f      (z_f),
        .n_f      (n_f),
        .v_f      (v_f),
        .c_f      (c_f),
        .flags_q  (flags_q)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    // Advance to just after the next rising edge, then defaults are kept
    // from the previous cycle unless the caller overrides them.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle, compare everything queued.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                chk_t c;
                logic [31:0] act;
                c = sb.pop_front();
                case (c.sel)
                    0:       act = rs1_data;
                    1:       act = rs2_data;
                    default: act = {28'h0, flags_q};
                endcase
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_we = 1'b0;
        rd_data = '0; flag_we = 1'b0; z_f = 1'b0; n_f = 1'b0; v_f = 1'b0; c_f = 1'b0;

        // c1: out of power-on reset; write x5
        next_cycle();
        rst = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd31;
        rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
        expect_val("por_rs1",   0, 32'h0);
        expect_val("por_rs2",   1, 32'h0);
        expect_val("por_flags", 2, 32'h0);

        // c2: x5 visible; reset asserted, reads still show contents
        next_cycle();
        rd_we = 1'b0; rst = 1'b1; rs1_addr = 5'd5;
        expect_val("x5_written",   0, 32'hDEAD_BEEF);

        // c3: after mid-program reset x5 is 0; attempt write to x0
        next_cycle();
        rst = 1'b0;
        rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF; rs2_addr = 5'd0;
        expect_val("rst_x5",        0, 32'h0);
        expect_val("rst_flags",     2, 32'h0);
        expect_val("x0_same_cycle", 1, 32'h0);

        // c4: x0 still zero on both ports; write x30
        next_cycle();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        rd_we = 1'b1; rd_addr = 5'd30; rd_data = 32'h0000_1234;
        expect_val("x0_rs1", 0, 32'h0);
        expect_val("x0_rs2", 1, 32'h0);

        // c5: write x31
        next_cycle();
        rd_we = 1'b1; rd_addr = 5'd31; rd_data = 32'h8000_0001;

        // c6: both ports read x31
        next_cycle();
        rd_we = 1'b0; rs1_addr = 5'd31; rs2_addr = 5'd31;
        expect_val("x31_rs1", 0, 32'h8000_0001);
        expect_val("x31_rs2", 1, 32'h8000_0001);

        // c7: x30 untouched by the x31 write; write x7=1
        next_cycle();
        rs1_addr = 5'd30;
        rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'h1;
        expect_val("x30_kept", 0, 32'h0000_1234);

        // c8: same-cycle hazard on x7
        next_cycle();
        rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'h2;
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        expect_val("hazard_rs2", 1, c_hazard_exp);
        expect_val("hazard_rs1", 0, c_hazard_exp);

        // c9: x7 settled; capture Z and C
        next_cycle();
        rd_we = 1'b0;
        flag_we = 1'b1; z_f = 1'b1; c_f = 1'b1; n_f = 1'b0; v_f = 1'b0;
        expect_val("x7_after_rs2", 1, 32'h2);
        expect_val("x7_after_rs1", 0, 32'h2);

        // c10: flags loaded; disable capture and change inputs
        next_cycle();
        flag_we = 1'b0; z_f = 1'b0;
        expect_val("flags_zc", 2, 32'h6);

        // c11: flags hold; capture N and V while writing x3
        next_cycle();
        flag_we = 1'b1; n_f = 1'b1; v_f = 1'b1; z_f = 1'b0; c_f = 1'b0;
        rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'h55;
        expect_val("flags_hold", 2, 32'h6);

        // c12: reset wins over a concurrent write and flag capture
        next_cycle();
        rst = 1'b1;
        rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'h66;
        flag_we = 1'b1; n_f = 1'b1; z_f = 1'b1; c_f = 1'b1; v_f = 1'b1;
        rs1_addr = 5'd3;
        expect_val("flags_nv",        2, 32'h9);
        expect_val("x3_during_rst",   0, 32'h55);

        // c13: after reset edge everything cleared
        next_cycle();
        rst = 1'b0; rd_we = 1'b0; flag_we = 1'b0; rs2_addr = 5'd31;
        expect_val("prio_x3",    0, 32'h0);
        expect_val("prio_flags", 2, 32'h0);
        expect_val("prio_x31",   1, 32'h0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d checks left unprocessed, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
